// File: rtl/apb_mem_slave_v2.sv
// apb_mem_slave_v2: parametrised APB4 scratch-RAM slave with byte strobes,
// a control/status register just above the memory (runtime wait states and
// write protect), and error responses for misaligned / out-of-range access.
module apb_mem_slave_v2 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int RESET_WAIT = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam int IW  = ADDR_WIDTH - LSB;
    localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t                  state;
    state_t                  next_state;
    logic [3:0]              cnt;
    logic [3:0]              next_cnt;
    logic [3:0]              csr_wait;
    logic                    csr_wp;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [IW-1:0]           idx;
    logic [MAW-1:0]          mem_idx;
    logic                    is_mem;
    logic                    is_csr;
    logic                    misaligned;
    logic                    err;
    logic                    commit;
    logic [DATA_WIDTH-1:0]   csr_val;
    logic [DATA_WIDTH-1:0]   rd_val;

    // Address decode, error classification and read-data mux
    always_comb begin
        idx        = PADDR[ADDR_WIDTH-1:LSB];
        mem_idx    = idx[MAW-1:0];
        is_mem     = (idx < IW'(DEPTH));
        is_csr     = (idx == IW'(DEPTH));
        misaligned = (PADDR[LSB-1:0] != '0);
        // Write-protect only blocks memory writes; the CSR stays writable so WP can be cleared.
        err        = misaligned || (!is_mem && !is_csr) || (PWRITE && is_mem && csr_wp);
        csr_val    = '0;
        csr_val[3:0] = csr_wait;
        csr_val[8]   = csr_wp;
        rd_val     = is_csr ? csr_val : mem[mem_idx];
        commit     = (state == ST_DONE) && PSEL && PENABLE && PWRITE && !err;
    end

    // FSM state and wait counter registers
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state logic: setup captures WAIT, WAIT counts down, DONE lasts one cycle
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            ST_IDLE: begin
                // PENABLE without a preceding setup cycle is not a transfer start.
                if (PSEL && !PENABLE) begin
                    if (csr_wait == 4'd0) begin
                        next_state = ST_DONE;
                    end else begin
                        next_state = ST_WAIT;
                        next_cnt   = csr_wait;
                    end
                end
            end
            ST_WAIT: begin
                next_cnt = cnt - 4'd1;
                if (!PSEL) begin
                    next_state = ST_IDLE;
                end else if (cnt == 4'd1) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    // Response registers: loaded on entry to DONE, cleared on every other cycle
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
            if (next_state == ST_DONE && state != ST_DONE) begin
                PREADY  <= 1'b1;
                PSLVERR <= err;
                if (!err && !PWRITE) begin
                    PRDATA <= rd_val;
                end
            end
        end
    end

    // CSR update at the end of the DONE cycle, per-field byte strobes
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            csr_wait <= 4'(RESET_WAIT);
            csr_wp   <= 1'b0;
        end else if (commit && is_csr) begin
            if (PSTRB[0]) csr_wait <= PWDATA[3:0];
            if (PSTRB[1]) csr_wp   <= PWDATA[8];
        end
    end

    // Memory byte-lane write; contents survive reset
    always_ff @(posedge PCLK) begin
        if (!PRESET && commit && is_mem) begin
            for (int i = 0; i < NB; i++) begin
                if (PSTRB[i]) mem[mem_idx][i*8 +: 8] <= PWDATA[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_apb_mem_slave_v2.sv
// Directed table-driven bench for apb_mem_slave_v2 (32-bit, 1024 words, CSR at 0x1000).
module tb_apb_mem_slave_v2;

    logic        clk;
    logic        preset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int checks = 0;
    int fails  = 0;

    apb_mem_slave_v2 #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1024), .RESET_WAIT(0)
    ) dut (
        .PCLK(clk), .PRESET(preset), .PSEL(psel), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          cyc;
        logic        err;
        logic [31:0] rdata;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int cyc, input logic err,
                       input logic [31:0] rdata, input string name);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
        v.cyc = cyc; v.err = err; v.rdata = rdata; v.name = name;
        vecs.push_back(v);
    endtask

    // One complete transfer; returns the access cycle in which PREADY was seen (-1 on timeout)
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output int cyc, output logic err,
                        output logic [31:0] rd, output logic rdy_after);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        cyc = 1;
        while (!pready && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!pready) cyc = -1;
        err = pslverr;
        rd  = prdata;
        @(posedge clk); #1;
        rdy_after = pready;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic run_check(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] strb, input int ecyc, input logic eerr,
                             input logic [31:0] erd, input string name);
        int          cyc;
        logic        err;
        logic [31:0] rd;
        logic        ra;
        xfer(wr, addr, wdata, strb, cyc, err, rd, ra);
        check({name, " ready_cycle"}, 32'(cyc), 32'(ecyc));
        check({name, " pslverr"}, {31'b0, err}, {31'b0, eerr});
        check({name, " prdata"}, rd, erd);
        check({name, " ready_drop"}, {31'b0, ra}, 32'b0);
    endtask

    initial begin
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;

        add(1, 32'h0010, 32'hDEADBEEF, 4'hF, 1, 0, 32'h0, "wr_0x10");
        add(0, 32'h0010, 32'h0,        4'h0, 1, 0, 32'hDEADBEEF, "rd_0x10");
        add(1, 32'h1000, 32'h3,        4'hF, 1, 0, 32'h0, "csr_wait3");
        add(0, 32'h0010, 32'h0,        4'h0, 4, 0, 32'hDEADBEEF, "rd_w3");
        add(0, 32'h1000, 32'h0,        4'h0, 4, 0, 32'h3, "rd_csr3");
        add(1, 32'h1000, 32'hFFFFFFFF, 4'h1, 4, 0, 32'h0, "csr_strb0_only");
        add(0, 32'h1000, 32'h0,        4'h0, 16, 0, 32'hF, "rd_csr_f");
        add(1, 32'h1000, 32'h0,        4'hF, 16, 0, 32'h0, "csr_wait0");
        add(1, 32'h0020, 32'h11223344, 4'hF, 1, 0, 32'h0, "wr_0x20");
        add(1, 32'h0020, 32'hAABBCCDD, 4'h5, 1, 0, 32'h0, "wr_strb5");
        add(0, 32'h0020, 32'h0,        4'h0, 1, 0, 32'h11BB33DD, "rd_strb5");
        add(1, 32'h0000, 32'h55AA55AA, 4'hF, 1, 0, 32'h0, "wr_0x0");
        add(0, 32'h1004, 32'h0,        4'h0, 1, 1, 32'h0, "rd_oor");
        add(1, 32'h1008, 32'h1,        4'hF, 1, 1, 32'h0, "wr_oor");
        add(1, 32'h0002, 32'h12345678, 4'hF, 1, 1, 32'h0, "wr_misal");
        add(0, 32'h0011, 32'h0,        4'h0, 1, 1, 32'h0, "rd_misal");
        add(0, 32'h0000, 32'h0,        4'h0, 1, 0, 32'h55AA55AA, "rd_0x0_kept");
        add(1, 32'h1000, 32'h100,      4'hF, 1, 0, 32'h0, "csr_wp1");
        add(0, 32'h1000, 32'h0,        4'h0, 1, 0, 32'h100, "rd_csr_wp");
        add(1, 32'h0010, 32'h12345678, 4'hF, 1, 1, 32'h0, "wr_protected");
        add(0, 32'h0010, 32'h0,        4'h0, 1, 0, 32'hDEADBEEF, "rd_protected");
        add(1, 32'h1000, 32'h0,        4'hF, 1, 0, 32'h0, "csr_wp0");
        add(1, 32'h0010, 32'hCAFEF00D, 4'hF, 1, 0, 32'h0, "wr_unprot");
        add(1, 32'h0010, 32'hFFFFFFFF, 4'h0, 1, 0, 32'h0, "wr_strb0");
        add(0, 32'h0010, 32'h0,        4'h0, 1, 0, 32'hCAFEF00D, "rd_unprot");

        repeat (2) @(posedge clk);
        #1;
        check("reset pready", {31'b0, pready}, 32'b0);
        check("reset pslverr", {31'b0, pslverr}, 32'b0);
        check("reset prdata", prdata, 32'h0);
        preset = 1'b0;

        foreach (vecs[i]) begin
            run_check(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                      vecs[i].cyc, vecs[i].err, vecs[i].rdata, vecs[i].name);
        end

        // PENABLE high in IDLE without a setup cycle: no response
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h0010;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("no_setup pready", {31'b0, pready}, 32'b0);
        end
        psel = 1'b0; penable = 1'b0;

        // Abort: WAIT=5, PSEL dropped after two access cycles of a write
        run_check(1, 32'h1000, 32'h5, 4'hF, 1, 0, 32'h0, "csr_wait5");
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0010; pwdata = 32'h0BADBAD0; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        check("abort acc1 pready", {31'b0, pready}, 32'b0);
        @(posedge clk); #1;
        check("abort acc2 pready", {31'b0, pready}, 32'b0);
        psel = 1'b0; penable = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            check("abort idle pready", {31'b0, pready}, 32'b0);
        end
        run_check(0, 32'h0010, 32'h0, 4'h0, 6, 0, 32'hCAFEF00D, "rd_after_abort");

        // Reset during the WAIT phase of a write
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0010; pwdata = 32'h0BADBAD0; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        preset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid pready", {31'b0, pready}, 32'b0);
        check("rst_mid pslverr", {31'b0, pslverr}, 32'b0);
        check("rst_mid prdata", prdata, 32'h0);
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        run_check(0, 32'h1000, 32'h0, 4'h0, 1, 0, 32'h0, "rd_csr_after_rst");
        run_check(0, 32'h0010, 32'h0, 4'h0, 1, 0, 32'hCAFEF00D, "rd_after_rst");

        // Reset during the DONE cycle of a write: write must not commit
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0010; pwdata = 32'h0BADBAD0; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        check("rst_done pready_before", {31'b0, pready}, 32'b1);
        preset = 1'b1;
        @(posedge clk); #1;
        check("rst_done pready", {31'b0, pready}, 32'b0);
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        run_check(0, 32'h0010, 32'h0, 4'h0, 1, 0, 32'hCAFEF00D, "rd_after_rst_done");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/apb_mem_slave_v2.md
Name: apb_mem_slave_v2

Overview:
Parametrised APB4 memory slave, the successor to the fixed 32-bit/1024-word APB slave. Adds configurable data width and depth, PSTRB byte-lane writes, and a control/status register (CSR) mapped directly above the memory. The CSR sets wait states at runtime and write-protects the memory. It also adds error responses for misaligned and out-of-range accesses. The block sits behind the APB bridge as a generic scratch RAM and test target.

Parameters:
ADDR_WIDTH, 32, PADDR width; must be large enough to reach the CSR.
DATA_WIDTH, 32, data bus width; legal values are 32 or 64.
DEPTH, 1024, number of memory words; any value of 1 or more.
RESET_WAIT, 0, reset value of the CSR WAIT field (0..15).

Ports:
PCLK  in  1  APB clock; all logic on rising edge.
PRESET  in  1  synchronous, active-high reset.
PSEL  in  1  slave select.
PENABLE  in  1  access phase.
PWRITE  in  1  1 = write, 0 = read.
PADDR  in  ADDR_WIDTH  byte address.
PWDATA  in  DATA_WIDTH  write data.
PSTRB  in  DATA_WIDTH/8  write byte strobes.
PRDATA  out  DATA_WIDTH  read data, registered.
PREADY  out  1  transfer complete, registered.
PSLVERR  out  1  error response, valid while PREADY=1, registered.

Behaviour:
- Single clock PCLK. Reset PRESET is synchronous and active-high.
- Reset values: PRDATA=0, PREADY=0, PSLVERR=0, FSM=IDLE, wait counter=0, CSR.WAIT=RESET_WAIT, CSR.WP=0.
- Reset does not clear memory contents.
- Reset asserted mid-transfer aborts the transfer with no write; outputs take reset values on the next edge.
- Address decode:
  - LSB = log2(DATA_WIDTH/8).
  - idx = PADDR[ADDR_WIDTH-1:LSB].
  - idx < DEPTH selects memory word idx.
  - idx == DEPTH selects the CSR.
  - idx > DEPTH is an out-of-range error.
  - PADDR[LSB-1:0] != 0 is a misalignment error, regardless of idx.
- CSR layout:
  - bits[3:0] WAIT: access wait states.
  - bit[8] WP: memory write-protect.
  - All other bits read 0 and ignore writes.
  - CSR writes honour PSTRB[0] (WAIT) and PSTRB[1] (WP).
  - CSR writes are allowed while WP=1.
- Write-protect: a memory write while WP=1 is an error; memory is unchanged.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: when PSEL=1 and PENABLE=0 (setup cycle), capture W = CSR.WAIT.
    - If W==0: go to DONE.
    - If W>0: load counter with W and go to WAIT.
  - WAIT: PREADY=0; counter decrements each cycle.
    - When counter==1: go to DONE.
    - If PSEL=0 at any edge: go to IDLE; no write, no outputs raised.
  - DONE: PREADY=1 for exactly one cycle; then go to IDLE with PREADY, PSLVERR and PRDATA all returning to 0.
- Latency: setup cycle + (W+1) access cycles. PREADY is high in the last access cycle.
- On entry to DONE (same edge as PREADY rises):
  - Error: PSLVERR<=1, PRDATA<=0.
  - Read, no error: PRDATA<=memory word or CSR value.
- Writes commit at the edge ending the DONE cycle, only when PSEL=1, PENABLE=1 and there is no error.
  - Memory writes update only byte lanes with PSTRB[i]=1.
  - PSTRB all zero is a legal no-op write.
- Address, control and PWDATA are sampled at the DONE-exit edge. The master must hold them stable per APB.
- Back-to-back transfers: the next setup cycle follows DONE immediately; no idle cycle is required.
- A new CSR.WAIT value applies from the next transfer's setup.
- PENABLE=1 seen in IDLE without a prior setup cycle is ignored: no response, FSM stays in IDLE.
- PSTRB is ignored on reads.

Test Plan (DATA_WIDTH=32, DEPTH=1024, CSR at 0x1000, RESET_WAIT=0):
- Reset, then write 0xDEADBEEF to 0x0010 (PSTRB=0xF), then read 0x0010 -> each transfer has PREADY high in the first access cycle; PRDATA=0xDEADBEEF, PSLVERR=0.
- Write 0x00000003 to CSR 0x1000, then read 0x0010 -> PREADY rises in the 4th access cycle; reading CSR returns 0x00000003.
- Word 0x0020 holds 0x11223344; write 0xAABBCCDD with PSTRB=0x5 -> readback 0x11BB33DD.
- Read 0x1004 and write 0x0002 -> both PSLVERR=1 with PRDATA=0; memory unchanged.
- Write CSR=0x100 (WP=1), then write 0x0010 -> PSLVERR=1 and word unchanged. Write CSR=0x000 -> the next memory write succeeds.
- With WAIT=5, drop PSEL after 2 access cycles of a write -> no PREADY, memory unchanged. Assert PRESET mid-transfer -> next cycle all outputs 0, CSR=0x000.
